// File: rtl/level_map.sv
// Writable level grid for the raycaster: init sweep loads a built-in layout,
// the game controller edits single cells, and the DDA stepper queries cells.
module level_map #(
    parameter int unsigned ROW_BITS  = 6,
    parameter int unsigned COL_BITS  = 6,
    parameter int unsigned CELL_BITS = 2,
    parameter int unsigned ROWS      = 64
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 init_req,
    input  logic                 init_level,
    output logic                 init_busy,
    input  logic                 w_en,
    input  logic [ROW_BITS-1:0]  w_row,
    input  logic [COL_BITS-1:0]  w_col,
    input  logic [CELL_BITS-1:0] w_cell,
    input  logic                 q_valid,
    output logic                 q_ready,
    input  logic [ROW_BITS-1:0]  q_row,
    input  logic [COL_BITS-1:0]  q_col,
    output logic                 r_valid,
    output logic [CELL_BITS-1:0] r_cell,
    output logic                 dbg_state
);

    // Handshake: a query is accepted in any cycle where q_valid && q_ready;
    // its response appears in the following cycle as a one-cycle r_valid
    // pulse with r_cell. There is no response backpressure.

    localparam int unsigned AW     = ROW_BITS + COL_BITS;
    localparam int unsigned DEPTH  = 1 << AW;
    localparam int unsigned ROWS_W = ROW_BITS + 1;
    localparam logic [ROWS_W-1:0] ROWS_L = ROWS_W'(ROWS);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_IDLE = 1'b1
    } state_t;

    state_t              state_q;
    logic [AW-1:0]       cnt_q;
    logic                level_q;
    logic                r_valid_q;
    logic [CELL_BITS-1:0] r_cell_q;

    logic [CELL_BITS-1:0] mem [DEPTH];

    logic                 mem_we_d;
    logic [AW-1:0]        mem_waddr_d;
    logic [CELL_BITS-1:0] mem_wdata_d;
    logic                 w_row_ok;
    logic                 q_row_ok;
    logic                 q_accept;

    function automatic logic [CELL_BITS-1:0] pattern(input logic lvl, input logic [AW-1:0] addr);
        logic [ROW_BITS-1:0] row;
        logic [COL_BITS-1:0] col;
        logic                solid;
        row = addr[AW-1:COL_BITS];
        col = addr[COL_BITS-1:0];
        if (lvl == 1'b0) begin
            solid = (row == '0) || (row == ROW_BITS'(ROWS - 1)) ||
                    (col == '0) || (col == '1);
        end else begin
            solid = ((col == COL_BITS'(0)) || (col == COL_BITS'(2))) &&
                    (row <= ROW_BITS'(4));
        end
        return solid ? CELL_BITS'(1) : '0;
    endfunction

    assign w_row_ok  = ({1'b0, w_row} < ROWS_L);
    assign q_row_ok  = ({1'b0, q_row} < ROWS_L);
    assign q_ready   = (state_q == ST_IDLE);
    assign q_accept  = q_valid && q_ready;
    assign init_busy = (state_q == ST_INIT);
    assign dbg_state = state_q;
    assign r_valid   = r_valid_q;
    assign r_cell    = r_cell_q;

    // Single write port: the sweep owns it during INIT; in IDLE an init
    // request takes precedence over a same-cycle edit.
    always_comb begin
        mem_we_d    = 1'b0;
        mem_waddr_d = cnt_q;
        mem_wdata_d = pattern(level_q, cnt_q);
        if (state_q == ST_INIT) begin
            mem_we_d = 1'b1;
        end else if (w_en && !init_req && w_row_ok) begin
            mem_we_d    = 1'b1;
            mem_waddr_d = {w_row, w_col};
            mem_wdata_d = w_cell;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we_d) begin
            mem[mem_waddr_d] <= mem_wdata_d;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    cnt_q <= cnt_q + AW'(1);
                    if (cnt_q == '1) begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (init_req) begin
                        level_q <= init_level;
                        cnt_q   <= '0;
                        state_q <= ST_INIT;
                    end
                end
                default: state_q <= ST_INIT;
            endcase
        end
    end

    // The read samples the array before any same-edge write lands, so a
    // query colliding with a write returns the old contents.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_valid_q <= 1'b0;
            r_cell_q  <= '0;
        end else begin
            r_valid_q <= q_accept;
            if (q_accept) begin
                r_cell_q <= q_row_ok ? mem[{q_row, q_col}] : CELL_BITS'(1);
            end
        end
    end

endmodule

// File: tb/tb_level_map.sv
// Directed bench for level_map: default 64-row grid plus a 40-row build,
// with a response scoreboard fed by the query driver.
module tb_level_map;

    logic       clk = 1'b0;
    logic       resetn;
    logic       init_req, init_level, init_busy;
    logic       w_en;
    logic [5:0] w_row, w_col;
    logic [1:0] w_cell;
    logic       q_valid, q_ready;
    logic [5:0] q_row, q_col;
    logic       r_valid;
    logic [1:0] r_cell;
    logic       dbg_state;

    logic       b_resetn, b_init_busy, b_q_valid, b_q_ready, b_r_valid, b_w_en;
    logic [5:0] b_w_row, b_w_col, b_q_row, b_q_col;
    logic [1:0] b_w_cell, b_r_cell;
    logic       b_dbg_state;

    int n_checks = 0;
    int n_fail   = 0;
    logic [1:0] exp_q[$];
    logic [1:0] exp40_q[$];

    always #5 clk = ~clk;

    level_map u_dut (
        .clk(clk), .resetn(resetn), .init_req(init_req), .init_level(init_level),
        .init_busy(init_busy), .w_en(w_en), .w_row(w_row), .w_col(w_col),
        .w_cell(w_cell), .q_valid(q_valid), .q_ready(q_ready), .q_row(q_row),
        .q_col(q_col), .r_valid(r_valid), .r_cell(r_cell), .dbg_state(dbg_state)
    );

    level_map #(.ROWS(40)) u_dut40 (
        .clk(clk), .resetn(b_resetn), .init_req(1'b0), .init_level(1'b0),
        .init_busy(b_init_busy), .w_en(b_w_en), .w_row(b_w_row), .w_col(b_w_col),
        .w_cell(b_w_cell), .q_valid(b_q_valid), .q_ready(b_q_ready), .q_row(b_q_row),
        .q_col(b_q_col), .r_valid(b_r_valid), .r_cell(b_r_cell), .dbg_state(b_dbg_state)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Scoreboards: every response pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (r_valid) begin
            if (exp_q.size() == 0) check("r_valid_unexpected", r_valid, 0);
            else check("r_cell", r_cell, exp_q.pop_front());
        end
        if (b_r_valid) begin
            if (exp40_q.size() == 0) check("r40_valid_unexpected", b_r_valid, 0);
            else check("r40_cell", b_r_cell, exp40_q.pop_front());
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic qry(input int r, input int c, input int e);
        q_valid = 1'b1; q_row = 6'(r); q_col = 6'(c);
        exp_q.push_back(2'(e));
        step();
        q_valid = 1'b0;
    endtask

    task automatic wr(input int r, input int c, input int d);
        w_en = 1'b1; w_row = 6'(r); w_col = 6'(c); w_cell = 2'(d);
        step();
        w_en = 1'b0;
    endtask

    task automatic qry40(input int r, input int c, input int e);
        b_q_valid = 1'b1; b_q_row = 6'(r); b_q_col = 6'(c);
        exp40_q.push_back(2'(e));
        step();
        b_q_valid = 1'b0;
    endtask

    // Counts busy cycles; at cycle pulse_at it fires init_req, a write and a
    // query into the running sweep, all of which must be ignored.
    task automatic wait_idle(input string tag, input int pulse_at);
        int n;
        n = 0;
        while (init_busy && n < 6000) begin
            if (n == pulse_at) begin
                init_req = 1'b1; init_level = 1'b0;
                w_en = 1'b1; w_row = 6'd0; w_col = 6'd2; w_cell = 2'd0;
                q_valid = 1'b1; q_row = 6'd0; q_col = 6'd0;
                check("init_q_ready", q_ready, 0);
            end
            n++;
            step();
            init_req = 1'b0; w_en = 1'b0; q_valid = 1'b0;
        end
        check(tag, n, 4096);
        check({tag, "_q_ready"}, q_ready, 1);
        check({tag, "_dbg_state"}, dbg_state, 1);
    endtask

    initial begin
        resetn = 1'b0; b_resetn = 1'b0;
        init_req = 1'b0; init_level = 1'b0;
        w_en = 1'b0; w_row = '0; w_col = '0; w_cell = '0;
        q_valid = 1'b0; q_row = '0; q_col = '0;
        b_w_en = 1'b0; b_w_row = '0; b_w_col = '0; b_w_cell = '0;
        b_q_valid = 1'b0; b_q_row = '0; b_q_col = '0;
        step(); step();
        check("rst_init_busy", init_busy, 1);
        check("rst_q_ready", q_ready, 0);
        check("rst_r_valid", r_valid, 0);
        check("rst_r_cell", r_cell, 0);
        resetn = 1'b1; b_resetn = 1'b1;
        wait_idle("busy_reset", -1);

        // Bordered room.
        qry(0, 5, 1);
        qry(63, 10, 1);
        qry(10, 63, 1);
        qry(10, 10, 0);

        // 40-row build: rows 40..63 are outside and read solid.
        check("b_init_busy", b_init_busy, 0);
        qry40(40, 0, 1);
        qry40(39, 5, 1);
        qry40(20, 5, 0);
        b_w_en = 1'b1; b_w_row = 6'd45; b_w_col = 6'd1; b_w_cell = 2'd0;
        b_q_valid = 1'b1; b_q_row = 6'd5; b_q_col = 6'd1;
        exp40_q.push_back(2'd0);
        step();
        b_w_en = 1'b0; b_q_valid = 1'b0;
        qry40(45, 1, 1);
        qry40(5, 1, 0);

        // Hallway load; the query issued with init_req still gets its answer.
        init_req = 1'b1; init_level = 1'b1;
        q_valid = 1'b1; q_row = 6'd10; q_col = 6'd63;
        exp_q.push_back(2'd1);
        step();
        init_req = 1'b0; q_valid = 1'b0;
        wait_idle("busy_level1", 100);
        qry(3, 0, 1);
        qry(4, 2, 1);
        qry(5, 0, 0);
        qry(0, 1, 0);
        qry(0, 63, 0);
        qry(0, 2, 1);

        // Edits: write-then-read, and read-before-write on collision.
        wr(10, 10, 3);
        qry(10, 10, 3);
        w_en = 1'b1; w_row = 6'd10; w_col = 6'd10; w_cell = 2'd2;
        qry(10, 10, 3);
        w_en = 1'b0;
        qry(10, 10, 2);

        // Reset 2000 cycles into a hallway sweep restarts a level-0 sweep.
        init_req = 1'b1; init_level = 1'b1;
        step();
        init_req = 1'b0;
        for (int i = 0; i < 2000; i++) step();
        resetn = 1'b0;
        #1;
        check("mid_rst_init_busy", init_busy, 1);
        check("mid_rst_q_ready", q_ready, 0);
        check("mid_rst_r_valid", r_valid, 0);
        check("mid_rst_r_cell", r_cell, 0);
        check("mid_rst_dbg_state", dbg_state, 0);
        step();
        resetn = 1'b1;
        wait_idle("busy_rerun", -1);
        qry(0, 5, 1);
        qry(63, 10, 1);
        qry(10, 63, 1);
        qry(10, 10, 0);
        qry(4, 2, 0);
        qry(0, 1, 1);

        step(); step();
        check("pending_responses", exp_q.size(), 0);
        check("pending_responses40", exp40_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

endmodule
